// File: rtl/lfsr_descrambler_par.sv
// rtl/lfsr_descrambler_par.sv - frame-synchronous parallel LFSR descrambler
module lfsr_descrambler_par #(
    parameter int                   DW       = 1,
    parameter int                   LFSR_LEN = 8,
    parameter logic [LFSR_LEN-1:0]  POLY     = 8'b1001_0101,
    parameter logic [LFSR_LEN-1:0]  SEED     = 8'hAA
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_sync_valid,
    input  logic [DW-1:0] i_sync_data,
    input  logic          i_sync_valid_pulse,
    input  logic          i_rx_end_pulse,
    input  logic          i_bypass,
    output logic [DW-1:0] o_ds_data,
    output logic          o_ds_valid,
    output logic          o_busy,
    output logic [15:0]   o_beat_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WORK = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          rst_sync;
    logic                run;
    logic [LFSR_LEN-1:0] lfsr;
    logic [LFSR_LEN-1:0] lfsr_adv;
    logic [DW-1:0]       keystream;
    logic                beat_en;

    // Assertion is immediate through rst_n; release waits two clocks so the
    // core never leaves reset on a metastable edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (!run) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sync has priority over end, and is honoured from either state.
    always_comb begin
        state_nxt = state;
        if (i_sync_valid_pulse) begin
            state_nxt = S_WORK;
        end else if (i_rx_end_pulse) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        o_busy  = (state == S_WORK);
        beat_en = (state == S_WORK) && i_sync_valid && !i_bypass;
    end

    // DW serial steps unrolled; output bit DW-1 uses the current MSB.
    always_comb begin
        lfsr_adv  = lfsr;
        keystream = '0;
        for (int k = 0; k < DW; k++) begin
            keystream[DW-1-k] = lfsr_adv[LFSR_LEN-1];
            lfsr_adv          = {lfsr_adv[LFSR_LEN-2:0], ^(lfsr_adv & POLY)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED;
            o_ds_data  <= '0;
            o_ds_valid <= 1'b0;
            o_beat_cnt <= '0;
        end else if (!run) begin
            lfsr       <= SEED;
            o_ds_data  <= '0;
            o_ds_valid <= 1'b0;
            o_beat_cnt <= '0;
        end else begin
            o_ds_valid <= i_sync_valid;

            if (state == S_IDLE) begin
                o_ds_data <= i_sync_data;
            end else if (i_sync_valid) begin
                o_ds_data <= i_bypass ? i_sync_data : (i_sync_data ^ keystream);
            end

            if (i_sync_valid_pulse || (state == S_IDLE)) begin
                lfsr <= SEED;
            end else if (beat_en) begin
                lfsr <= lfsr_adv;
            end

            if (i_sync_valid_pulse) begin
                o_beat_cnt <= '0;
            end else if (beat_en && (o_beat_cnt != 16'hFFFF)) begin
                o_beat_cnt <= o_beat_cnt + 16'd1;
            end
        end
    end

endmodule
